button_classifier: RTL and testbench

BUTTON_CLASSIFIER -- requirements
Module: button_classifier

---
 rtl/button_classifier.sv | 148 ++++++++++++++
 tb/tb_button_classifier.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_classifier.sv
// button_classifier: debounces an active-low push-button and classifies each
// accepted press as short (B_S pulse on release) or long (B_L pulse once the
// hold time elapses). A 2-flop synchronizer feeds a five-state FSM that shares
// one saturating 26-bit counter for debounce, hold and repeat timing.
// Optional feature macro: BTN_AUTO_REPEAT_EN -- while a long press is still
// held, emit a further B_L pulse every REPEAT_CYCLES cycles.
// Handshake: none; B_S and B_L are single-cycle registered pulses with no
// valid/ready pairing, and pressed is a registered level.
module button_classifier #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clk_50MHz,
  input  logic       reset_n,
  input  logic       btn_n,
  input  logic       En,
  output logic       B_S,
  output logic       B_L,
  output logic       pressed,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DEB_PRESS = 3'd1;
  localparam logic [2:0] HELD      = 3'd2;
  localparam logic [2:0] LONG      = 3'd3;
  localparam logic [2:0] DEB_REL   = 3'd4;

  localparam logic [25:0] CNT_MAX  = '1;
  localparam logic [25:0] DEB_LAST = 26'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [25:0] REP_LAST = 26'(REPEAT_CYCLES - 1);
`endif

  // Every timing parameter must fit the 26-bit counter and be at least 1.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 67108864 ||
      LONG_CYCLES < 1 || LONG_CYCLES > 67108864 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > 67108864) begin : g_param_check
    $fatal(1, "button_classifier: timing parameter out of range");
  end

  logic        sync1, btn_s;
  logic [2:0]  state, state_nx;
  logic [25:0] cnt, cnt_nx, cnt_inc;
  logic        short_flag, short_flag_nx;
  logic        pressed_nx, bs_nx, bl_nx;

  assign fsm_state = state;
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 26'd1;

  // Two-flop synchronizer; both stages reset to the released level (1).
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= btn_n;
      btn_s <= sync1;
    end
  end

  // Next-state, counter and pulse decode; En low overrides everything.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt_inc;
    short_flag_nx = short_flag;
    pressed_nx    = pressed;
    bs_nx         = 1'b0;
    bl_nx         = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!btn_s) state_nx = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (btn_s) begin
          state_nx = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nx   = HELD;
          pressed_nx = 1'b1;
        end
      end
      HELD: begin
        if (btn_s) begin
          state_nx      = DEB_REL;
          short_flag_nx = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nx = LONG;
          bl_nx    = 1'b1;
        end
      end
      LONG: begin
        if (btn_s) begin
          state_nx      = DEB_REL;
          short_flag_nx = 1'b0;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (cnt == REP_LAST) begin
          bl_nx  = 1'b1;
          cnt_nx = '0;
        end
`endif
      end
      DEB_REL: begin
        if (!btn_s) begin
          // Release bounce: resume the press; hold time restarts from 0.
          state_nx = short_flag ? HELD : LONG;
        end else if (cnt == DEB_LAST) begin
          state_nx   = IDLE;
          pressed_nx = 1'b0;
          bs_nx      = short_flag;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) cnt_nx = '0;
    if (!En) begin
      state_nx      = IDLE;
      cnt_nx        = '0;
      short_flag_nx = 1'b0;
      pressed_nx    = 1'b0;
      bs_nx         = 1'b0;
      bl_nx         = 1'b0;
    end
  end

  // FSM state, shared counter and registered outputs.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      short_flag <= 1'b0;
      pressed    <= 1'b0;
      B_S        <= 1'b0;
      B_L        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      short_flag <= short_flag_nx;
      pressed    <= pressed_nx;
      B_S        <= bs_nx;
      B_L        <= bl_nx;
    end
  end

endmodule

// File: tb/tb_button_classifier.sv
// tb_button_classifier: directed table of button waveforms with hand-computed
// pulse counts and pressed durations, plus hand-written En-drop and
// reset-mid-pulse sequences. Parameters DEBOUNCE=4, LONG=20, REPEAT=8.
module tb_button_classifier;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_n = 1'b1;
  logic       en = 1'b1;
  logic       b_s, b_l, pressed;
  logic [2:0] fsm_state;

  localparam logic [2:0] ST_IDLE = 3'd0;

  int n_vec  = 0;
  int n_fail = 0;

  // Window counters, sampled on the falling edge.
  int cyc = 0, bs_cnt = 0, bl_cnt = 0, p_cyc = 0, overlap = 0;
  int p_first = -1, bl_first = -1;

  button_classifier #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk_50MHz(clk),
    .reset_n(reset_n),
    .btn_n(btn_n),
    .En(en),
    .B_S(b_s),
    .B_L(b_l),
    .pressed(pressed),
    .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: counts pulses and pressed cycles inside the current window.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (b_s) bs_cnt = bs_cnt + 1;
    if (b_l) begin
      bl_cnt = bl_cnt + 1;
      if (bl_first < 0) bl_first = cyc;
    end
    if (pressed) begin
      p_cyc = p_cyc + 1;
      if (p_first < 0) p_first = cyc;
    end
    if (b_s && b_l) overlap = overlap + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_window();
    bs_cnt = 0; bl_cnt = 0; p_cyc = 0; overlap = 0;
    p_first = -1; bl_first = -1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] pat;   // bit i = 1: button pressed during cycle i
    int          len;
    int          exp_bs;
    int          exp_bl;
    int          exp_pcyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Table: a press lasting L cycles is accepted iff L >= 5, becomes long
    // iff L >= 25, and keeps pressed high for exactly L cycles.
    vecs[0] = '{64'h3FF,        10, 1, 0, 10};  // clean short press
    vecs[1] = '{64'h1F,          5, 1, 0, 5};   // shortest accepted press
    vecs[2] = '{64'hF,           4, 0, 0, 0};   // one sample too short
    vecs[3] = '{64'h333,        12, 0, 0, 0};   // bouncy, toggles every 2
    vecs[4] = '{64'hFFFFFF,     24, 1, 0, 24};  // released one cycle before long
    vecs[5] = '{64'h1FFFFFF,    25, 0, 1, 25};  // just long
`ifdef BTN_AUTO_REPEAT_EN
    vecs[6] = '{64'hFF_FFFF_FFFF, 40, 0, 2, 40}; // long plus one repeat
`else
    vecs[6] = '{64'hFF_FFFF_FFFF, 40, 0, 1, 40}; // long hold
`endif
    vecs[7] = '{64'h13FF,       13, 1, 0, 13};  // release bounce back to HELD

    // Reset state.
    step();
    step();
    check("reset_bs", int'(b_s), 0);
    check("reset_bl", int'(b_l), 0);
    check("reset_pressed", int'(pressed), 0);
    check("reset_state", int'(fsm_state), int'(ST_IDLE));
    reset_n = 1'b1;
    step();
    step();

    // Table-driven vectors.
    for (int v = 0; v < 8; v++) begin
      clear_window();
      for (int i = 0; i < vecs[v].len + 12; i++) begin
        btn_n = (i < 64) ? ~vecs[v].pat[i] : 1'b1;
        step();
      end
      check($sformatf("v%0d_bs", v), bs_cnt, vecs[v].exp_bs);
      check($sformatf("v%0d_bl", v), bl_cnt, vecs[v].exp_bl);
      check($sformatf("v%0d_pressed_cycles", v), p_cyc, vecs[v].exp_pcyc);
      check($sformatf("v%0d_overlap", v), overlap, 0);
      check($sformatf("v%0d_end_state", v), int'(fsm_state), int'(ST_IDLE));
      if (vecs[v].exp_bl > 0)
        check($sformatf("v%0d_bl_latency", v), bl_first - p_first, 20);
    end

    // En dropped for one cycle while HELD, button still held.
    clear_window();
    btn_n = 1'b0;
    for (int i = 0; i < 20 && !pressed; i++) step();
    check("en_press_accept", int'(pressed), 1);
    step();
    step();
    en = 1'b0;
    step();
    check("en_drop_pressed", int'(pressed), 0);
    check("en_drop_state", int'(fsm_state), int'(ST_IDLE));
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("en_redeb_not_yet", int'(pressed), 0);
    step();
    check("en_redeb_pressed", int'(pressed), 1);
    btn_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("en_seq_bs", bs_cnt, 1);
    check("en_seq_bl", bl_cnt, 0);

    // Reset asserted while B_L is high, button kept held.
    clear_window();
    btn_n = 1'b0;
    for (int i = 0; i < 40 && !b_l; i++) step();
    check("rst_saw_bl", int'(b_l), 1);
    reset_n = 1'b0;
    #1;
    check("rst_bl_async", int'(b_l), 0);
    check("rst_pressed_async", int'(pressed), 0);
    check("rst_state_async", int'(fsm_state), int'(ST_IDLE));
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("rst_redeb_not_yet", int'(pressed), 0);
    step();
    check("rst_redeb_pressed", int'(pressed), 1);
    clear_window();
    btn_n = 1'b1;
    for (int i = 0; i < 14; i++) step();
    check("rst_seq_bs", bs_cnt, 1);
    check("rst_seq_bl", bl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
